o_writeback_buffer: RTL and testbench

// Dual-banked output (O-vector) buffer between the backend PEs and the memory controller.
// - Captures one full tile of NUM_ROWS O vectors from the PEs in parallel in one cycle.
// - Drains that tile row by row to memory over a valid/ready write channel.
// - Ping-pong banks: the PEs can deposit the next tile while the previous tile drains.

---
 rtl/sys_defs.sv | 20 ++
 rtl/owb_bank.sv | 37 +++
 rtl/o_writeback_buffer.sv | 144 ++++++++++++++
 tb/tb_o_writeback_buffer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared definitions for the backend output path: O-vector type, PE count,
// memory address width and the writeback drain state encoding.
`ifndef NUM_PES
`define NUM_PES 4
`endif

package sys_defs;

  localparam int NUM_PES    = `NUM_PES;
  localparam int MEM_ADDR_W = 32;
  localparam int O_VECTOR_W = 32;

  typedef logic [O_VECTOR_W-1:0] O_VECTOR_T;

  typedef enum logic {
    DRAIN_IDLE   = 1'b0,
    DRAIN_ACTIVE = 1'b1
  } drain_state_e;

endpackage

// File: rtl/owb_bank.sv
// One tile of O-vector storage: all rows written in parallel in a single
// cycle, one row read back combinationally by index. Contents survive reset.
module owb_bank
  import sys_defs::*;
#(
  parameter int NUM_ROWS = NUM_PES,
  parameter int IDX_W    = $clog2(NUM_ROWS)
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  O_VECTOR_T [NUM_ROWS-1:0]   wr_rows,
  input  logic      [IDX_W-1:0]      rd_idx,
  output O_VECTOR_T                  rd_row
);

  O_VECTOR_T [NUM_ROWS-1:0] mem_q;
  O_VECTOR_T [NUM_ROWS-1:0] mem_d;

  // Replace the whole tile when written, otherwise hold.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d = wr_rows;
    end
  end

  // Storage register; deliberately not reset so a tile costs no clear cycle.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Combinational row select for the drain side.
  always_comb begin
    rd_row = mem_q[rd_idx];
  end

endmodule

// File: rtl/o_writeback_buffer.sv
// Ping-pong O-vector writeback buffer: captures a full tile from the PEs in
// one cycle and drains it row by row to memory over a valid/ready channel,
// while the other bank can accept the next tile.
module o_writeback_buffer
  import sys_defs::*;
#(
  parameter int NUM_ROWS   = NUM_PES,
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int ROW_STRIDE = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      capture_valid,
  output logic                      capture_ready,
  input  O_VECTOR_T [NUM_ROWS-1:0]  capture_data,
  input  logic      [ADDR_W-1:0]    tile_base_addr,
  output logic                      wr_valid,
  input  logic                      wr_ready,
  output logic      [ADDR_W-1:0]    wr_addr,
  output O_VECTOR_T                 wr_data,
  output logic                      tile_done,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_ROWS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ROWS - 1);

  logic [1:0]        full_q, full_d;
  logic              fill_bank_q, fill_bank_d;
  logic              drain_bank_q, drain_bank_d;
  logic [ADDR_W-1:0] base_q [2];
  logic [ADDR_W-1:0] base_d [2];
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic              tile_done_q, tile_done_d;
  drain_state_e      state_q, state_d;

  logic              cap_fire;
  logic              wr_fire;
  logic              tile_finish;
  logic [1:0]        bank_we;
  O_VECTOR_T         bank_rd [2];

  // Two identical banks; only the fill bank is written on a capture.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    owb_bank #(
      .NUM_ROWS (NUM_ROWS),
      .IDX_W    (IDX_W)
    ) u_bank (
      .clk     (clk),
      .wr_en   (bank_we[b]),
      .wr_rows (capture_data),
      .rd_idx  (rd_idx_q),
      .rd_row  (bank_rd[b])
    );
  end

  // Handshake qualifiers and datapath outputs, all from registered state.
  always_comb begin
    capture_ready = !full_q[fill_bank_q];
    cap_fire      = capture_valid && capture_ready;
    wr_valid      = (state_q == DRAIN_ACTIVE);
    wr_fire       = wr_valid && wr_ready;
    tile_finish   = wr_fire && (rd_idx_q == LAST_IDX);
    bank_we       = 2'b00;
    bank_we[fill_bank_q] = cap_fire;
    wr_data       = bank_rd[drain_bank_q];
    wr_addr       = base_q[drain_bank_q] + (ADDR_W'(rd_idx_q) * ADDR_W'(ROW_STRIDE));
    tile_done     = tile_done_q;
    busy          = full_q[0] | full_q[1];
  end

  // Bank bookkeeping: capture fills one bank while the drain frees the other.
  // A capture needs its bank empty and a finish needs its bank full, so the
  // two never target the same bank in one cycle.
  always_comb begin
    full_d       = full_q;
    fill_bank_d  = fill_bank_q;
    drain_bank_d = drain_bank_q;
    base_d       = base_q;
    if (cap_fire) begin
      full_d[fill_bank_q] = 1'b1;
      base_d[fill_bank_q] = tile_base_addr;
      fill_bank_d         = !fill_bank_q;
    end
    if (tile_finish) begin
      full_d[drain_bank_q] = 1'b0;
      drain_bank_d         = !drain_bank_q;
    end
  end

  // Drain FSM next state: walk rows of the drain bank, idle one cycle between tiles.
  always_comb begin
    state_d     = state_q;
    rd_idx_d    = rd_idx_q;
    tile_done_d = 1'b0;
    case (state_q)
      DRAIN_IDLE: begin
        rd_idx_d = '0;
        if (full_q[drain_bank_q]) begin
          state_d = DRAIN_ACTIVE;
        end
      end
      DRAIN_ACTIVE: begin
        if (wr_fire) begin
          if (rd_idx_q == LAST_IDX) begin
            rd_idx_d    = '0;
            tile_done_d = 1'b1;
            state_d     = DRAIN_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d  = DRAIN_IDLE;
        rd_idx_d = '0;
      end
    endcase
  end

  // State registers; reset drops pending tiles but leaves bank contents alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q       <= 2'b00;
      fill_bank_q  <= 1'b0;
      drain_bank_q <= 1'b0;
      base_q[0]    <= '0;
      base_q[1]    <= '0;
      rd_idx_q     <= '0;
      tile_done_q  <= 1'b0;
      state_q      <= DRAIN_IDLE;
    end else begin
      full_q       <= full_d;
      fill_bank_q  <= fill_bank_d;
      drain_bank_q <= drain_bank_d;
      base_q[0]    <= base_d[0];
      base_q[1]    <= base_d[1];
      rd_idx_q     <= rd_idx_d;
      tile_done_q  <= tile_done_d;
      state_q      <= state_d;
    end
  end

endmodule

// File: tb/tb_o_writeback_buffer.sv
// Scoreboard bench for o_writeback_buffer: directed tiles push expected rows,
// a negedge monitor pops and compares every accepted write.
module tb_o_writeback_buffer;
  import sys_defs::*;

  localparam int NR = 4;

  typedef struct {
    logic [31:0] addr;
    O_VECTOR_T   data;
    logic        last;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  capture_valid;
  logic                  capture_ready;
  O_VECTOR_T [NR-1:0]    capture_data;
  logic [31:0]           tile_base_addr;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [31:0]           wr_addr;
  O_VECTOR_T             wr_data;
  logic                  tile_done;
  logic                  busy;

  exp_t        exp_q[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  int          hs_count = 0;
  logic        prev_stall = 1'b0;
  logic        prev_last = 1'b0;
  logic        prev_mid = 1'b0;
  logic [31:0] prev_addr = '0;
  O_VECTOR_T   prev_data = '0;

  o_writeback_buffer #(
    .NUM_ROWS   (NR),
    .ADDR_W     (32),
    .ROW_STRIDE (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .capture_valid  (capture_valid),
    .capture_ready  (capture_ready),
    .capture_data   (capture_data),
    .tile_base_addr (tile_base_addr),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .tile_done      (tile_done),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic push_tile(input logic [31:0] base, input O_VECTOR_T [NR-1:0] rows);
    exp_t e;
    for (int i = 0; i < NR; i++) begin
      e.addr = base + 32'(i * 64);
      e.data = rows[i];
      e.last = (i == NR - 1);
      exp_q.push_back(e);
    end
  endtask

  // Present a tile and hold it until accepted (bounded).
  task automatic do_capture(input logic [31:0] base, input O_VECTOR_T [NR-1:0] rows);
    bit accepted;
    accepted = 0;
    capture_valid  = 1'b1;
    capture_data   = rows;
    tile_base_addr = base;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (capture_ready) begin
        accepted = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    capture_valid = 1'b0;
    check("capture_accepted", 64'(accepted), 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !wr_valid) break;
    end
    check("drain_complete", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: score every accepted row, stall stability, gaps and tile_done.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
      prev_last  = 1'b0;
      prev_mid   = 1'b0;
    end else begin
      check("tile_done", 64'(tile_done), 64'(prev_last));
      if (prev_stall) begin
        check("stall_valid_held", 64'(wr_valid), 64'd1);
        check("stall_addr_held", 64'(wr_addr), 64'(prev_addr));
        check("stall_data_held", 64'(wr_data), 64'(prev_data));
      end
      if (prev_mid) begin
        check("no_gap_in_tile", 64'(wr_valid), 64'd1);
      end
      prev_last = 1'b0;
      prev_mid  = 1'b0;
      if (wr_valid && wr_ready) begin
        hs_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_row_addr", 64'(wr_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("row_addr", 64'(wr_addr), 64'(e.addr));
          check("row_data", 64'(wr_data), 64'(e.data));
          prev_last = e.last;
          prev_mid  = !e.last;
        end
      end
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end
  end

  initial begin
    O_VECTOR_T [NR-1:0] t_a;
    O_VECTOR_T [NR-1:0] t_b;
    O_VECTOR_T [NR-1:0] t_c;
    logic [4:0] pat;
    int start;
    bit seen;

    rst            = 1'b1;
    capture_valid  = 1'b0;
    capture_data   = '0;
    tile_base_addr = '0;
    wr_ready       = 1'b0;

    // 1: reset
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_wr_valid", 64'(wr_valid), 64'd0);
    check("reset_capture_ready", 64'(capture_ready), 64'd1);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_tile_done", 64'(tile_done), 64'd0);

    // 2: single tile, no backpressure
    @(posedge clk);
    #1;
    wr_ready = 1'b1;
    t_a = {32'h44, 32'h33, 32'h22, 32'h11};
    push_tile(32'h1000, t_a);
    do_capture(32'h1000, t_a);
    wait_drain();
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);

    // 3: backpressure pattern 0,1,0,0,1
    @(posedge clk);
    #1;
    wr_ready = 1'b0;
    pat = 5'b10010;
    t_a = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    push_tile(32'h1000, t_a);
    start = hs_count;
    do_capture(32'h1000, t_a);
    for (int i = 0; i < 300; i++) begin
      wr_ready = pat[i % 5];
      @(negedge clk);
      if (exp_q.size() == 0 && !wr_valid) break;
      @(posedge clk);
      #1;
    end
    check("bp_drained", 64'(exp_q.size()), 64'd0);
    check("bp_transfer_count", 64'(hs_count - start), 64'd4);

    // 4: ping-pong, both banks full, third capture refused
    @(posedge clk);
    #1;
    wr_ready = 1'b0;
    t_a = {32'hA4, 32'hA3, 32'hA2, 32'hA1};
    t_b = {32'hB4, 32'hB3, 32'hB2, 32'hB1};
    push_tile(32'h1000, t_a);
    do_capture(32'h1000, t_a);
    push_tile(32'h2000, t_b);
    do_capture(32'h2000, t_b);
    @(negedge clk);
    check("pp_capture_ready_full", 64'(capture_ready), 64'd0);
    check("pp_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1;
    capture_valid  = 1'b1;
    capture_data   = {32'hDEAD, 32'hDEAD, 32'hDEAD, 32'hDEAD};
    tile_base_addr = 32'h9000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("pp_third_refused", 64'(capture_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    capture_valid = 1'b0;
    wr_ready      = 1'b1;
    wait_drain();

    // 5: collision of A's last-row handshake with a waiting capture
    @(posedge clk);
    #1;
    wr_ready = 1'b0;
    t_c = {32'hC4, 32'hC3, 32'hC2, 32'hC1};
    push_tile(32'h1000, t_a);
    do_capture(32'h1000, t_a);
    push_tile(32'h2000, t_b);
    do_capture(32'h2000, t_b);
    push_tile(32'h4000, t_c);
    capture_valid  = 1'b1;
    capture_data   = t_c;
    tile_base_addr = 32'h4000;
    wr_ready       = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_valid && wr_ready && wr_addr == 32'h10C0) begin
        check("collide_refused", 64'(capture_ready), 64'd0);
        @(negedge clk);
        check("collide_accepted_next", 64'(capture_ready), 64'd1);
        seen = 1;
        break;
      end
    end
    check("collide_last_row_seen", 64'(seen), 64'd1);
    @(posedge clk);
    #1;
    capture_valid = 1'b0;
    wait_drain();

    // 6: reset in the middle of a drain
    @(posedge clk);
    #1;
    wr_ready = 1'b1;
    push_tile(32'h1000, t_a);
    start = hs_count;
    do_capture(32'h1000, t_a);
    for (int i = 0; i < 50; i++) begin
      if (hs_count >= start + 2) break;
      @(negedge clk);
    end
    check("mid_two_rows", 64'(hs_count - start), 64'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_wr_valid", 64'(wr_valid), 64'd0);
    check("mid_rst_capture_ready", 64'(capture_ready), 64'd1);
    check("mid_rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    t_c = {32'hE4, 32'hE3, 32'hE2, 32'hE1};
    push_tile(32'h3000, t_c);
    do_capture(32'h3000, t_c);
    wait_drain();

    @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
